// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fetch_pkg
// Purpose  : Shared definitions for the SCC instruction-fetch stage: FSM
//            state encoding, default reset PC and the PC increment per word
//            (also used by ID/EX branch-target logic).
// Ports    : none (package)
// Revision : 1.0 - initial prefetching fetch engine
// ============================================================================
package fetch_pkg;

  localparam int unsigned c_STATE_W = 1;
  typedef logic [c_STATE_W-1:0] state_t;

  localparam state_t c_ST_RUN    = 1'b0;
  localparam state_t c_ST_HALTED = 1'b1;

  localparam logic [31:0] c_DEFAULT_RESET_PC = 32'h0000_0000;
  localparam int unsigned c_PC_STEP          = 4;

endpackage : fetch_pkg
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : fetch_queue
// Purpose  : Synchronous FIFO holding prefetched {instr, pc} words.
//            flush has priority over push and pop.
// Ports    : clk, reset          - clock, synchronous active-high reset
//            push / din          - write one entry
//            pop                 - consume head entry
//            flush               - empty the queue, pointers back to 0
//            dout                - head entry (valid when !empty)
//            count, full, empty  - occupancy status
// Revision : 1.0 - initial prefetching fetch engine
// ============================================================================
module fetch_queue #(
  parameter  int unsigned DEPTH = 4,
  parameter  int unsigned W     = 64,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [W-1:0]     din,
  output logic [W-1:0]     dout,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] rd_q;
  logic [PTR_W-1:0] wr_q;
  logic [CNT_W-1:0] count_q;
  logic             w_do_push;
  logic             w_do_pop;

  assign full      = (count_q == CNT_W'(DEPTH));
  assign empty     = (count_q == '0);
  assign w_do_push = push & ~full & ~flush;
  assign w_do_pop  = pop & ~empty & ~flush;

  // DEPTH is a power of two, so the pointers wrap by plain overflow.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
    end else begin
      if (w_do_push) wr_q <= wr_q + PTR_W'(1);
      if (w_do_pop)  rd_q <= rd_q + PTR_W'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  generate
    for (genvar i = 0; i < DEPTH; i++) begin : g_entry
      always_ff @(posedge clk) begin
        if (reset) begin
          mem_q[i] <= '0;
        end else if (w_do_push && (wr_q == PTR_W'(i))) begin
          mem_q[i] <= din;
        end
      end
    end
  endgenerate

  assign dout  = mem_q[rd_q];
  assign count = count_q;

endmodule : fetch_queue
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Purpose  : Prefetching, stallable instruction-fetch stage. Owns the PC,
//            issues reads to a 1-cycle-latency instruction memory, buffers
//            returned words and hands them to ID over valid/ready.
//            Supports branch redirect (with flush) and a halt mode.
// Ports    : clk, reset                 - clock, synchronous active-high reset
//            in_mem_addr, in_mem_en     - request to instruction memory
//            in_mem                     - word returned one cycle after request
//            instr, instr_pc, instr_valid - head of queue towards ID
//            id_ready                   - ID accepts head this cycle
//            redirect_valid, redirect_pc - load new PC, flush queue
//            halt_req, halted           - stop issuing / halted status
// Revision : 1.0 - initial prefetching fetch engine
// ============================================================================
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned       ADDR_W      = 32,
  parameter int unsigned       INSTR_W     = 32,
  parameter int unsigned       QUEUE_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC    = ADDR_W'(c_DEFAULT_RESET_PC),
  parameter int unsigned       PC_STEP     = c_PC_STEP
) (
  input  logic               clk,
  input  logic               reset,
  output logic [ADDR_W-1:0]  in_mem_addr,
  output logic               in_mem_en,
  input  logic [INSTR_W-1:0] in_mem,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic               instr_valid,
  input  logic               id_ready,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  input  logic               halt_req,
  output logic               halted
);

  localparam int unsigned CNT_W = $clog2(QUEUE_DEPTH) + 1;
  localparam int unsigned Q_W   = INSTR_W + ADDR_W;

  state_t              state_q;
  state_t              state_d;
  logic [ADDR_W-1:0]   pc_q;
  logic [ADDR_W-1:0]   pc_d;
  logic                inflight_q;
  logic [ADDR_W-1:0]   inflight_pc_q;

  logic [CNT_W-1:0]    w_q_count;
  logic                w_q_full;
  logic                w_q_empty;
  logic [Q_W-1:0]      w_q_dout;
  logic                w_pop;
  logic [CNT_W:0]      w_used;
  logic                w_credit_ok;
  logic                w_issue;

  // Credit: a request may only be issued if its response is guaranteed a
  // slot. Pops in this cycle are deliberately not counted as credit.
  // The full term is redundant with the sum but keeps the check explicit.
  assign w_used      = {1'b0, w_q_count} + {{CNT_W{1'b0}}, inflight_q};
  assign w_credit_ok = ~w_q_full & (w_used < (CNT_W+1)'(QUEUE_DEPTH));

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= c_ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next state. Redirect always wins and is the only exit from HALTED.
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    if (redirect_valid) begin
      state_d = c_ST_RUN;
    end else if ((state_q == c_ST_RUN) && halt_req) begin
      state_d = c_ST_HALTED;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: outputs
  // --------------------------------------------------------------------------
  always_comb begin
    halted  = (state_q == c_ST_HALTED);
    w_issue = (state_q == c_ST_RUN) & ~reset & ~redirect_valid & w_credit_ok;
  end

  // --------------------------------------------------------------------------
  // PC and in-flight tracking
  // --------------------------------------------------------------------------
  always_comb begin
    pc_d = pc_q;
    if (redirect_valid) begin
      pc_d = redirect_pc;
    end else if (w_issue) begin
      pc_d = pc_q + ADDR_W'(PC_STEP);
    end
  end

  // A redirect never issues, so inflight_q drops and the response that
  // arrives in the following cycle is never pushed.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
    end else begin
      pc_q       <= pc_d;
      inflight_q <= w_issue;
      if (w_issue) begin
        inflight_pc_q <= pc_q;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Prefetch queue. A response landing in a redirect cycle is discarded
  // because flush has priority over push.
  // --------------------------------------------------------------------------
  assign w_pop = ~w_q_empty & id_ready;

  fetch_queue #(
    .DEPTH (QUEUE_DEPTH),
    .W     (Q_W)
  ) u_queue (
    .clk   (clk),
    .reset (reset),
    .push  (inflight_q),
    .pop   (w_pop),
    .flush (redirect_valid),
    .din   ({in_mem, inflight_pc_q}),
    .dout  (w_q_dout),
    .count (w_q_count),
    .full  (w_q_full),
    .empty (w_q_empty)
  );

  assign in_mem_en   = w_issue;
  assign in_mem_addr = pc_q;
  assign instr_valid = ~w_q_empty;
  assign instr       = w_q_empty ? '0 : w_q_dout[Q_W-1:ADDR_W];
  assign instr_pc    = w_q_empty ? '0 : w_q_dout[ADDR_W-1:0];

endmodule : fetch_unit
`default_nettype wire
